// File: rtl/vending_machine_pkg.sv
// vending_machine_pkg: state codes, item count, price table and credit limit.
package vending_machine_pkg;
    localparam int NUM_ITEMS = 10;
    localparam int CREDIT_MAX = 31;
    typedef enum logic [4:0] {
        ST_USER     = 5'd0,
        ST_DISPENSE = 5'd1,
        ST_REFUND   = 5'd2,
        ST_LOCK     = 5'd16,
        ST_ADMIN    = 5'd17
    } state_t;
    localparam logic [2:0] PRICE [NUM_ITEMS] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
endpackage

// File: rtl/vending_machine_edge_detect.sv
// edge_detect: rising-edge detector; history resets to 1 so buttons held through reset do not fire.
module edge_detect (
    input  logic clk,
    input  logic res,
    input  logic din,
    output logic rise
);
    logic prev;
    always_ff @(posedge clk or posedge res)
        if (res) prev <= 1'b1;
        else     prev <= din;
    assign rise = din & ~prev;
endmodule

// File: rtl/vending_machine.sv
// vending_machine: credit/stock controller with user purchase mode and password-locked admin restock mode.
module vending_machine
    import vending_machine_pkg::*;
#(
    parameter logic [3:0] ADMIN_PSWRD = 4'b1010,
    parameter logic [2:0] STOCK_INIT  = 3'd3,
    parameter logic [2:0] STOCK_FULL  = 3'd7
) (
    input  logic       clk,
    input  logic       res,
    input  logic       mode,
    input  logic       ent,
    input  logic [0:3] pswrd,
    input  logic [0:2] mon,
    input  logic [0:3] it_no,
    input  logic       rem,
    input  logic       add_mon,
    output logic       err_pswrd,
    output logic       err_it_no,
    output logic       suc_it_no,
    output logic       suc_rem,
    output logic [0:4] state,
    output logic [0:9] all_led
);
    state_t cur, nxt;
    logic [4:0] credit, n_credit;
    logic [2:0] stock [NUM_ITEMS];
    logic [2:0] n_stock [NUM_ITEMS];
    logic rise_ent, rise_rem, rise_add;
    logic n_err_pswrd, n_err_it_no, n_suc_it_no, n_suc_rem;
    logic valid, can_buy;
    logic [2:0] price;
    logic [5:0] sum;

    edge_detect u_ent (.clk(clk), .res(res), .din(ent),     .rise(rise_ent));
    edge_detect u_rem (.clk(clk), .res(res), .din(rem),     .rise(rise_rem));
    edge_detect u_add (.clk(clk), .res(res), .din(add_mon), .rise(rise_add));

    assign valid   = it_no <= 4'd9;
    assign price   = valid ? PRICE[it_no] : 3'd0;
    assign can_buy = valid && stock[it_no] != 3'd0 && credit >= {2'b00, price};
    assign sum     = {1'b0, credit} + {3'b000, mon};
    assign state   = cur;

    always_ff @(posedge clk or posedge res)
        if (res) begin
            cur         <= ST_USER;
            credit      <= '0;
            err_pswrd   <= 1'b0;
            err_it_no   <= 1'b0;
            suc_it_no   <= 1'b0;
            suc_rem     <= 1'b0;
            all_led     <= {NUM_ITEMS{STOCK_INIT != 3'd0}};
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_INIT;
        end else begin
            cur         <= nxt;
            credit      <= n_credit;
            err_pswrd   <= n_err_pswrd;
            err_it_no   <= n_err_it_no;
            suc_it_no   <= n_suc_it_no;
            suc_rem     <= n_suc_rem;
            stock       <= n_stock;
            for (int i = 0; i < NUM_ITEMS; i++) all_led[i] <= stock[i] != 3'd0;
        end

    // A mode change wins over any button edge seen in the same cycle.
    always_comb begin
        nxt = cur;
        case (cur)
            ST_USER:
                nxt = mode ? ST_LOCK
                    : rise_rem ? (credit != '0 ? ST_REFUND : ST_USER)
                    : (rise_ent && can_buy) ? ST_DISPENSE : ST_USER;
            ST_DISPENSE, ST_REFUND: nxt = mode ? ST_LOCK : ST_USER;
            ST_LOCK:  nxt = !mode ? ST_USER : (rise_ent && pswrd == ADMIN_PSWRD) ? ST_ADMIN : ST_LOCK;
            ST_ADMIN: nxt = mode ? ST_ADMIN : ST_USER;
            default:  nxt = ST_USER;
        endcase
    end

    always_comb begin
        n_credit    = credit;
        n_stock     = stock;
        n_err_pswrd = 1'b0;
        n_err_it_no = 1'b0;
        n_suc_it_no = 1'b0;
        n_suc_rem   = 1'b0;
        if (cur == ST_USER && !mode) begin
            if (rise_rem) begin
                if (credit != '0) begin
                    n_credit  = '0;
                    n_suc_rem = 1'b1;
                end
            end else if (rise_ent) begin
                if (can_buy) begin
                    n_credit       = credit - {2'b00, price};
                    n_stock[it_no] = stock[it_no] - 3'd1;
                    n_suc_it_no    = 1'b1;
                end else n_err_it_no = 1'b1;
            end else if (rise_add) n_credit = sum > 6'(CREDIT_MAX) ? 5'(CREDIT_MAX) : sum[4:0];
        end else if (cur == ST_LOCK && mode) begin
            n_err_pswrd = rise_ent && pswrd != ADMIN_PSWRD;
        end else if (cur == ST_ADMIN && mode) begin
            if (rise_rem) begin
                if (valid) n_stock[it_no] = 3'd0;
                n_suc_rem   = valid;
                n_err_it_no = !valid;
            end else if (rise_ent) begin
                if (valid) n_stock[it_no] = STOCK_FULL;
                n_suc_it_no = valid;
                n_err_it_no = !valid;
            end
        end
    end
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed checks of purchase, refund, saturation, sell-out, admin and reset behaviour.
module tb_vending_machine;
  logic       clk = 1'b0;
  logic       res, mode, ent, rem, add_mon;
  logic [0:3] pswrd, it_no;
  logic [0:2] mon;
  logic       err_pswrd, err_it_no, suc_it_no, suc_rem;
  logic [0:4] state;
  logic [0:9] all_led;
  int n_chk = 0, n_fail = 0;
  logic [4:0] s_state;
  logic s_err_p, s_err_i, s_suc_i, s_suc_r;
  vending_machine dut (
    .clk(clk), .res(res), .mode(mode), .ent(ent), .pswrd(pswrd), .mon(mon),
    .it_no(it_no), .rem(rem), .add_mon(add_mon), .err_pswrd(err_pswrd),
    .err_it_no(err_it_no), .suc_it_no(suc_it_no), .suc_rem(suc_rem),
    .state(state), .all_led(all_led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input int which);
    ent = (which == 0); rem = (which == 1); add_mon = (which == 2);
    cyc();
    s_state = state; s_err_p = err_pswrd; s_err_i = err_it_no; s_suc_i = suc_it_no; s_suc_r = suc_rem;
    ent = 1'b0; rem = 1'b0; add_mon = 1'b0;
    cyc();
  endtask
  initial begin
    res = 1'b1; mode = 1'b0; ent = 1'b1; rem = 1'b0; add_mon = 1'b0;
    pswrd = 4'd0; mon = 3'd0; it_no = 4'd0;
    cyc(); cyc();
    chk("reset_state", state, 5'd0);
    chk("reset_led", all_led, 10'h3FF);
    chk("reset_pulses", {err_pswrd, err_it_no, suc_it_no, suc_rem}, 4'b0000);
    res = 1'b0;
    cyc(); cyc();
    chk("held_ent_no_pulse", err_it_no, 1'b0);
    ent = 1'b0; cyc();
    press(0);
    chk("fresh_ent_err", s_err_i, 1'b1);
    chk("err_one_cycle", err_it_no, 1'b0);
    mon = 3'd2; press(2); press(2);
    chk("credit_4", dut.credit, 5'd4);
    it_no = 4'd2; press(0);
    chk("buy2_suc", s_suc_i, 1'b1);
    chk("buy2_state_disp", s_state, 5'd1);
    chk("buy2_state_back", state, 5'd0);
    chk("buy2_suc_gone", suc_it_no, 1'b0);
    chk("buy2_led", all_led, 10'h3FF);
    chk("credit_1", dut.credit, 5'd1);
    it_no = 4'd4; press(0);
    chk("poor_err", s_err_i, 1'b1);
    chk("poor_no_suc", s_suc_i, 1'b0);
    chk("poor_credit", dut.credit, 5'd1);
    it_no = 4'd12; press(0);
    chk("bad_item_err", s_err_i, 1'b1);
    press(1);
    chk("refund_suc", s_suc_r, 1'b1);
    chk("refund_state", s_state, 5'd2);
    chk("refund_back", state, 5'd0);
    chk("refund_credit", dut.credit, 5'd0);
    press(1);
    chk("refund_empty", s_suc_r, 1'b0);
    mon = 3'd7;
    repeat (5) press(2);
    chk("credit_sat", dut.credit, 5'd31);
    it_no = 4'd4; press(0);
    chk("sat_buy_suc", s_suc_i, 1'b1);
    chk("credit_26", dut.credit, 5'd26);
    it_no = 4'd0;
    repeat (3) press(0);
    chk("soldout_led0", all_led[0], 1'b0);
    chk("soldout_credit", dut.credit, 5'd23);
    press(0);
    chk("soldout_err", s_err_i, 1'b1);
    chk("soldout_credit_kept", dut.credit, 5'd23);
    mode = 1'b1; cyc();
    chk("lock_state", state, 5'd16);
    pswrd = 4'd0; press(0);
    chk("bad_pw_err", s_err_p, 1'b1);
    chk("bad_pw_state", state, 5'd16);
    pswrd = 4'b1010; press(0);
    chk("good_pw_state", s_state, 5'd17);
    chk("good_pw_no_err", s_err_p, 1'b0);
    it_no = 4'd1; press(1);
    chk("admin_rem_suc", s_suc_r, 1'b1);
    chk("admin_rem_led", all_led[1], 1'b0);
    press(0);
    chk("admin_fill_suc", s_suc_i, 1'b1);
    chk("admin_fill_led", all_led[1], 1'b1);
    chk("admin_fill_stock", dut.stock[1], 3'd7);
    it_no = 4'd11; press(1);
    chk("admin_bad_item", s_err_i, 1'b1);
    mode = 1'b0; cyc();
    chk("back_user", state, 5'd0);
    chk("credit_retained", dut.credit, 5'd23);
    mode = 1'b1; cyc();
    chk("relocked", state, 5'd16);
    mode = 1'b0; cyc();
    it_no = 4'd1; mode = 1'b1; ent = 1'b1; cyc();
    chk("mode_prio_state", state, 5'd16);
    chk("mode_prio_no_suc", suc_it_no, 1'b0);
    chk("mode_prio_credit", dut.credit, 5'd23);
    ent = 1'b0; mode = 1'b0; cyc();
    chk("mode_prio_user", state, 5'd0);
    add_mon = 1'b1; #2 res = 1'b1; #1;
    chk("async_credit", dut.credit, 5'd0);
    chk("async_state", state, 5'd0);
    chk("async_led", all_led, 10'h3FF);
    chk("async_stock0", dut.stock[0], 3'd3);
    add_mon = 1'b0; cyc(); res = 1'b0; cyc();
    chk("post_reset_credit", dut.credit, 5'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
